commit_free_list: RTL and testbench

- Physical-register free list at the rename end of the commit path.
- Consumes commit notifications (commit val/wen/ppreg) from the writeback/commit unit and returns each committed instruction's previous physical register (ppreg) to a circular free pool.
- Supplies free physical registers to the rename stage through a rdy/en allocation handshake.
- Closes the preg lifecycle: rename allocates a preg, commit frees the superseded one.

---
 rtl/commit_free_list_if.sv | 32 +++
 rtl/commit_free_list.sv | 73 +++++++
 tb/tb_commit_free_list.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/commit_free_list_if.sv
// rtl/commit_free_list_if.sv - rename allocation and commit free handshake bundle
interface commit_free_list_if #(
    parameter int p_phys_addr_bits = 6
);
    logic                        alloc_rdy;
    logic                        alloc_en;
    logic [p_phys_addr_bits-1:0] alloc_preg;
    logic                        commit_val;
    logic                        commit_wen;
    logic [p_phys_addr_bits-1:0] commit_ppreg;
    logic [p_phys_addr_bits:0]   free_count;

    modport slave (
        output alloc_rdy,
        output alloc_preg,
        output free_count,
        input  alloc_en,
        input  commit_val,
        input  commit_wen,
        input  commit_ppreg
    );

    modport master (
        input  alloc_rdy,
        input  alloc_preg,
        input  free_count,
        output alloc_en,
        output commit_val,
        output commit_wen,
        output commit_ppreg
    );
endinterface

// File: rtl/commit_free_list.sv
// rtl/commit_free_list.sv - circular physical-register free list between commit and rename
module commit_free_list #(
    parameter int p_phys_addr_bits = 6,
    parameter int p_num_phys_regs  = 2 ** p_phys_addr_bits,
    parameter int p_num_arch_regs  = 32
) (
    input  logic           clk,
    input  logic           rst,
    commit_free_list_if.slave fl
);
    localparam int                        c_init_free = p_num_phys_regs - p_num_arch_regs;
    localparam logic [p_phys_addr_bits:0] c_full      = (p_phys_addr_bits+1)'(p_num_phys_regs);

    logic [p_phys_addr_bits-1:0] buf_q [p_num_phys_regs];
    logic [p_phys_addr_bits-1:0] head_q;
    logic [p_phys_addr_bits-1:0] tail_q;
    logic [p_phys_addr_bits:0]   count_q;

    logic alloc_rdy;
    logic fire;
    logic free_fire;
    logic free_ok;

    // alloc_rdy is a pure function of state, so a same-cycle free can never make it rise
    assign alloc_rdy = (count_q != '0);
    assign fire      = fl.alloc_en & alloc_rdy;
    assign free_fire = fl.commit_val & fl.commit_wen & (fl.commit_ppreg != '0);
    assign free_ok   = free_fire & (count_q != c_full);

    assign fl.alloc_rdy  = alloc_rdy;
    assign fl.alloc_preg = buf_q[head_q];
    assign fl.free_count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < p_num_phys_regs; i++) begin
                buf_q[i] <= (i < c_init_free) ? p_phys_addr_bits'(p_num_arch_regs + i) : '0;
            end
            head_q  <= '0;
            tail_q  <= p_phys_addr_bits'(c_init_free);
            count_q <= (p_phys_addr_bits+1)'(c_init_free);
        end else begin
            if (free_ok) begin
                buf_q[tail_q] <= fl.commit_ppreg;
                tail_q        <= tail_q + 1'b1;
            end
            if (fire) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_q + {{p_phys_addr_bits{1'b0}}, free_ok}
                               - {{p_phys_addr_bits{1'b0}}, fire};
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(fl.alloc_en && !alloc_rdy))
                else $error("commit_free_list: alloc_en with empty free list");
            assert (!(free_fire && count_q == c_full))
                else $error("commit_free_list: free into full list dropped");
        end
    end

    function automatic string linetrace();
        string s;
        s = $sformatf("%02h:%02h:%02h", head_q, tail_q, count_q);
        if (fire)    s = {s, $sformatf(" A%02h", buf_q[head_q])};
        if (free_ok) s = {s, $sformatf(" F%02h", fl.commit_ppreg)};
        return s;
    endfunction
`endif
endmodule

// File: tb/tb_commit_free_list.sv
// tb/tb_commit_free_list.sv - randomized self-checking bench against a queue-based free list model
module tb_commit_free_list;
    localparam int c_bits = 6;
    localparam int c_np   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    commit_free_list_if #(.p_phys_addr_bits(c_bits)) fl ();

    commit_free_list #(.p_phys_addr_bits(c_bits)) dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl.slave)
    );

    int checks = 0;
    int errors = 0;

    int free_q[$];
    int out_q[$];
    bit in_use[c_np];
    bit model_valid = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        free_q = {};
        out_q  = {};
        for (int i = 32; i < c_np; i++) free_q.push_back(i);
        for (int i = 1; i < 32; i++) out_q.push_back(i);
        for (int i = 0; i < c_np; i++) in_use[i] = (i < 32);
        model_valid = 1;
    endtask

    // Drive one cycle from posedge+1, compare at negedge, update model at the edge
    task automatic cycle(input logic r, input logic en, input logic v, input logic w, input int pp);
        int  size0;
        int  got;
        bit  do_alloc;
        bit  do_free;
        rst             = r;
        fl.alloc_en     = en;
        fl.commit_val   = v;
        fl.commit_wen   = w;
        fl.commit_ppreg = c_bits'(pp);
        @(negedge clk);
        if (model_valid) begin
            chk("alloc_rdy", int'(fl.alloc_rdy), int'(free_q.size() != 0));
            chk("free_count", int'(fl.free_count), free_q.size());
            if (free_q.size() != 0) chk("alloc_preg", int'(fl.alloc_preg), free_q[0]);
        end
        size0    = free_q.size();
        do_alloc = !r && en && size0 != 0;
        do_free  = !r && v && w && pp != 0 && size0 < c_np;
        got      = int'(fl.alloc_preg);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (do_alloc) begin
                got = free_q.pop_front();
                chk("no_dup_alloc", int'(in_use[got]), 0);
                in_use[got] = 1;
                out_q.push_back(got);
            end
            if (do_free) begin
                free_q.push_back(pp);
                in_use[pp] = 0;
                foreach (out_q[k]) begin
                    if (out_q[k] == pp) begin
                        out_q.delete(k);
                        break;
                    end
                end
            end
        end
        #1;
    endtask

    initial begin
        int en;
        int v;
        int w;
        int pp;
        int idx;

        fl.alloc_en     = 1'b0;
        fl.commit_val   = 1'b0;
        fl.commit_wen   = 1'b0;
        fl.commit_ppreg = '0;
        @(posedge clk);
        #1;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("rst_rdy", int'(fl.alloc_rdy), 1);
        chk("rst_preg", int'(fl.alloc_preg), 32);
        chk("rst_count", int'(fl.free_count), 32);

        for (int i = 0; i < 3; i++) begin
            chk("t1_preg", int'(fl.alloc_preg), 32 + i);
            cycle(0, 1, 0, 0, 0);
            chk("t1_count", int'(fl.free_count), 31 - i);
        end

        for (int i = 0; i < 29; i++) cycle(0, 1, 0, 0, 0);
        chk("t2_empty_rdy", int'(fl.alloc_rdy), 0);
        chk("t2_empty_count", int'(fl.free_count), 0);
        cycle(0, 0, 1, 1, 40);
        chk("t2_rdy", int'(fl.alloc_rdy), 1);
        chk("t2_preg", int'(fl.alloc_preg), 40);
        chk("t2_count", int'(fl.free_count), 1);

        chk("t3_preg_before", int'(fl.alloc_preg), 40);
        cycle(0, 1, 1, 1, 7);
        chk("t3_count", int'(fl.free_count), 1);
        chk("t3_preg", int'(fl.alloc_preg), 7);

        cycle(0, 0, 1, 0, 12);
        cycle(0, 0, 0, 1, 13);
        cycle(0, 0, 1, 1, 0);
        chk("t4_count", int'(fl.free_count), 1);
        cycle(0, 1, 0, 0, 0);
        chk("t4_empty", int'(fl.alloc_rdy), 0);

        for (int i = 0; i < 200; i++) begin
            en = (free_q.size() != 0) ? int'($urandom_range(0, 1)) : 0;
            if (out_q.size() != 0 && ($urandom % 3) != 0) begin
                idx = int'($urandom_range(0, out_q.size() - 1));
                pp  = out_q[idx];
                v   = 1;
                w   = (($urandom % 8) != 0) ? 1 : 0;
            end else if (($urandom % 2) != 0) begin
                v  = int'($urandom_range(0, 1));
                w  = 0;
                pp = int'($urandom_range(1, c_np - 1));
            end else begin
                v  = 1;
                w  = 1;
                pp = 0;
            end
            cycle(0, en[0], v[0], w[0], pp);
        end

        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 27; i++) cycle(0, 1, 0, 0, 0);
        chk("t6_count_before", int'(fl.free_count), 5);
        cycle(1, 0, 1, 1, 9);
        chk("t6_count", int'(fl.free_count), 32);
        chk("t6_preg", int'(fl.alloc_preg), 32);
        for (int i = 0; i < 32; i++) begin
            chk("t6_seq", int'(fl.alloc_preg), 32 + i);
            cycle(0, 1, 0, 0, 0);
        end
        chk("t6_drained", int'(fl.free_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
